// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron bank: FSM states, saturation limits
// and the effective-threshold rule (non-positive thresholds behave as 1).
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lif_state_t;

  function automatic int VMAX(input int vw);
    return (1 << (vw - 1)) - 1;
  endfunction

  function automatic int VMIN(input int vw);
    return -(1 << (vw - 1));
  endfunction

  function automatic int eff_threshold(input int thr);
    return (thr < 1) ? 1 : thr;
  endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational single-neuron LIF step: leak, integrate, saturate, same-step fire check.
// Shared by the time-multiplexed bank; also usable replicated in a parallel bank.
module lif_neuron_update
  import lif_pkg::*;
#(
  parameter int VW = 8,
  parameter int RW = 5,
  parameter int DW = 3
) (
  input  logic signed [VW-1:0] v,
  input  logic        [RW-1:0] cnt,
  input  logic signed [VW-1:0] cur,
  input  logic signed [VW-1:0] threshold,
  input  logic        [DW-1:0] decay,
  input  logic        [RW-1:0] refractory_period,
  output logic signed [VW-1:0] v_next,
  output logic        [RW-1:0] cnt_next,
  output logic                 spike
);

  localparam int EW = VW + 2;
  localparam logic signed [EW-1:0] SAT_HI = EW'(VMAX(VW));
  localparam logic signed [EW-1:0] SAT_LO = EW'(VMIN(VW));

  logic signed [EW-1:0] v_ext;
  logic signed [EW-1:0] i_ext;
  logic signed [EW-1:0] leak;
  logic signed [EW-1:0] u;
  logic signed [VW-1:0] vs;
  logic signed [VW-1:0] thr_eff;
  logic                 refractory;

  always_comb begin
    v_ext      = {{2{v[VW-1]}}, v};
    i_ext      = {{2{cur[VW-1]}}, cur};
    refractory = (cnt != '0);

    // A shift of VW or more would leave only sign bits; treat it as full leak.
    if (decay == '0) begin
      leak = '0;
    end else if (int'(decay) >= VW) begin
      leak = v_ext;
    end else begin
      leak = v_ext >>> decay;
    end

    u = refractory ? (v_ext - leak) : (v_ext - leak + i_ext);

    if (u > SAT_HI) begin
      vs = SAT_HI[VW-1:0];
    end else if (u < SAT_LO) begin
      vs = SAT_LO[VW-1:0];
    end else begin
      vs = u[VW-1:0];
    end

    thr_eff = VW'(eff_threshold(int'(threshold)));
    spike   = !refractory && (vs >= thr_eff);
    v_next  = spike ? (vs - thr_eff) : vs;

    if (refractory) begin
      cnt_next = cnt - RW'(1);
    end else if (spike) begin
      cnt_next = refractory_period;
    end else begin
      cnt_next = '0;
    end
  end

endmodule

// File: rtl/lif_neuron_bank.sv
// Bank of N_NEURONS LIF neurons updated one per clock through a shared datapath.
// Optional per-neuron saturating spike counters under `LIF_BANK_SPIKE_COUNT_EN`.
module lif_neuron_bank
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int VW        = 8,
  parameter int RW        = 5,
  parameter int DW        = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N_NEURONS*VW-1:0]     input_currents,
  input  logic signed [VW-1:0]        threshold,
  input  logic [DW-1:0]               decay,
  input  logic [RW-1:0]               refractory_period,
`ifdef LIF_BANK_SPIKE_COUNT_EN
  input  logic                        clear_counts,
  output logic [N_NEURONS*8-1:0]      spike_counts,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [N_NEURONS-1:0]        spikes,
  output logic [N_NEURONS*VW-1:0]     membrane_potential_out
);

  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  lif_state_t state;
  lif_state_t state_next;
  logic       accept;
  logic       step;
  logic       finish;

  logic [IW-1:0]            idx;
  logic [N_NEURONS*VW-1:0]  cur_sh;
  logic signed [VW-1:0]     thr_sh;
  logic [DW-1:0]            decay_sh;
  logic [RW-1:0]            period_sh;

  logic signed [VW-1:0]     v_mem   [N_NEURONS];
  logic [RW-1:0]            cnt_mem [N_NEURONS];
  logic [N_NEURONS-1:0]     pending;

  logic signed [VW-1:0]     v_sel;
  logic signed [VW-1:0]     i_sel;
  logic [RW-1:0]            cnt_sel;
  logic signed [VW-1:0]     v_upd;
  logic [RW-1:0]            cnt_upd;
  logic                     spike_upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign v_sel   = v_mem[idx];
  assign cnt_sel = cnt_mem[idx];
  assign i_sel   = cur_sh[idx*VW +: VW];

  lif_neuron_update #(
    .VW (VW),
    .RW (RW),
    .DW (DW)
  ) u_update (
    .v                 (v_sel),
    .cnt               (cnt_sel),
    .cur               (i_sel),
    .threshold         (thr_sh),
    .decay             (decay_sh),
    .refractory_period (period_sh),
    .v_next            (v_upd),
    .cnt_next          (cnt_upd),
    .spike             (spike_upd)
  );

  // Parameters are shadowed at acceptance so the timestep sees one consistent set.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      spikes    <= '0;
      pending   <= '0;
      idx       <= '0;
      cur_sh    <= '0;
      thr_sh    <= '0;
      decay_sh  <= '0;
      period_sh <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n]   <= '0;
        cnt_mem[n] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (accept) begin
        cur_sh    <= input_currents;
        thr_sh    <= threshold;
        decay_sh  <= decay;
        period_sh <= refractory_period;
        idx       <= '0;
        busy      <= 1'b1;
      end
      if (step) begin
        v_mem[idx]   <= v_upd;
        cnt_mem[idx] <= cnt_upd;
        pending[idx] <= spike_upd;
        if (idx != LAST) begin
          idx <= idx + IW'(1);
        end
      end
      if (finish) begin
        spikes <= pending;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

`ifdef LIF_BANK_SPIKE_COUNT_EN
  logic [7:0] count_mem [N_NEURONS];

  always_ff @(posedge clk) begin
    if (reset || (accept && clear_counts)) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        count_mem[n] <= '0;
      end
    end else if (step && spike_upd && (count_mem[idx] != 8'hFF)) begin
      count_mem[idx] <= count_mem[idx] + 8'd1;
    end
  end
`endif

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_out
    assign membrane_potential_out[g*VW +: VW] = v_mem[g];
`ifdef LIF_BANK_SPIKE_COUNT_EN
    assign spike_counts[g*8 +: 8] = count_mem[g];
`endif
  end

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Self-checking bench for lif_neuron_bank (N=4, VW=8, RW=5) against an integer model.
module tb_lif_neuron_bank;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int RW = 5;
  localparam int DW = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [N*VW-1:0]     input_currents;
  logic signed [VW-1:0] threshold;
  logic [DW-1:0]       decay;
  logic [RW-1:0]       refractory_period;
  logic                busy;
  logic                done;
  logic [N-1:0]        spikes;
  logic [N*VW-1:0]     membrane_potential_out;
`ifdef LIF_BANK_SPIKE_COUNT_EN
  logic                clear_counts;
  logic [N*8-1:0]      spike_counts;
`endif

  lif_neuron_bank #(
    .N_NEURONS (N),
    .VW        (VW),
    .RW        (RW),
    .DW        (DW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .input_currents         (input_currents),
    .threshold              (threshold),
    .decay                  (decay),
    .refractory_period      (refractory_period),
`ifdef LIF_BANK_SPIKE_COUNT_EN
    .clear_counts           (clear_counts),
    .spike_counts           (spike_counts),
`endif
    .busy                   (busy),
    .done                   (done),
    .spikes                 (spikes),
    .membrane_potential_out (membrane_potential_out)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model state: potentials, refractory counters, last spikes, spike counts.
  int           mv[N];
  int           mc[N];
  int           mcount[N];
  logic [N-1:0] mspk;
  int           ev[N];
  int           ec[N];
  logic [N-1:0] espk;

  int leak_pos[5] = '{8, 4, 2, 1, 1};
  int leak_neg[5] = '{-8, -4, -2, -1, 0};

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_v(input int n);
    logic signed [VW-1:0] t;
    t = membrane_potential_out[n*VW +: VW];
    return int'(t);
  endfunction

`ifdef LIF_BANK_SPIKE_COUNT_EN
  function automatic int dut_cnt(input int n);
    logic [7:0] t;
    t = spike_counts[n*8 +: 8];
    return int'(t);
  endfunction
`endif

  function automatic void model_clear();
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mc[n] = 0;
      mcount[n] = 0;
    end
    mspk = '0;
  endfunction

  function automatic void model_step(input logic [N*VW-1:0] cur, input int thr,
                                     input int dec, input int per);
    int teff;
    int v;
    int l;
    int u;
    int i;
    logic signed [VW-1:0] ib;
    teff = (thr < 1) ? 1 : thr;
    for (int n = 0; n < N; n++) begin
      ib = cur[n*VW +: VW];
      i  = int'(ib);
      v  = mv[n];
      if (dec == 0)       l = 0;
      else if (dec >= VW) l = v;
      else                l = v >>> dec;
      u = (mc[n] > 0) ? (v - l) : (v - l + i);
      if (u > 127)  u = 127;
      if (u < -128) u = -128;
      if (mc[n] > 0) begin
        ev[n] = u; ec[n] = mc[n] - 1; espk[n] = 1'b0;
      end else if (u >= teff) begin
        ev[n] = u - teff; ec[n] = per; espk[n] = 1'b1;
      end else begin
        ev[n] = u; ec[n] = 0; espk[n] = 1'b0;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_spikes", int'(spikes), 0);
    for (int n = 0; n < N; n++) begin
      chk("reset_v", dut_v(n), 0);
`ifdef LIF_BANK_SPIKE_COUNT_EN
      chk("reset_count", dut_cnt(n), 0);
`endif
    end
  endtask

  // One timestep: start, per-cycle potential walk, done pulse, held result.
  task automatic do_step(input logic [N*VW-1:0] cur, input int thr, input int dec,
                         input int per, input bit clr, input bit poke);
    model_step(cur, thr, dec, per);
    @(negedge clk);
    start             = 1'b1;
    input_currents    = cur;
    threshold         = VW'(thr);
    decay             = DW'(dec);
    refractory_period = RW'(per);
`ifdef LIF_BANK_SPIKE_COUNT_EN
    clear_counts      = clr;
`endif
    @(negedge clk);
    start             = poke;
    input_currents    = $urandom;
    threshold         = VW'($urandom);
    decay             = DW'($urandom);
    refractory_period = RW'($urandom);
`ifdef LIF_BANK_SPIKE_COUNT_EN
    clear_counts      = 1'($urandom);
`endif
    if (clr) begin
      for (int n = 0; n < N; n++) mcount[n] = 0;
    end
    chk("busy_accept", int'(busy), 1);
    chk("done_early", int'(done), 0);
    for (int n = 0; n < N; n++) chk("v_before_run", dut_v(n), mv[n]);
    for (int j = 1; j <= N; j++) begin
      @(negedge clk);
      if (j == N) start = 1'b0;
      chk("busy_run", int'(busy), 1);
      chk("done_run", int'(done), 0);
      chk("spikes_held_run", int'(spikes), int'(mspk));
      for (int n = 0; n < N; n++) chk("v_run", dut_v(n), (n < j) ? ev[n] : mv[n]);
    end
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("busy_clear", int'(busy), 0);
    chk("spikes", int'(spikes), int'(espk));
    for (int n = 0; n < N; n++) begin
      mv[n] = ev[n];
      mc[n] = ec[n];
      if (espk[n] && mcount[n] < 255) mcount[n]++;
      chk("v_done", dut_v(n), mv[n]);
`ifdef LIF_BANK_SPIKE_COUNT_EN
      chk("spike_count", dut_cnt(n), mcount[n]);
`endif
    end
    mspk = espk;
    @(negedge clk);
    chk("done_width", int'(done), 0);
    chk("spikes_held", int'(spikes), int'(mspk));
  endtask

  initial begin
    logic [N*VW-1:0] cur;
    reset             = 1'b1;
    start             = 1'b0;
    input_currents    = '0;
    threshold         = '0;
    decay             = '0;
    refractory_period = '0;
`ifdef LIF_BANK_SPIKE_COUNT_EN
    clear_counts      = 1'b0;
`endif
    model_clear();
    do_reset();

    // Integrate and fire on the third step.
    cur = {4{8'd7}};
    do_step(cur, 20, 0, 0, 1'b0, 1'b0);
    chk("lit_int1", dut_v(0), 7);
    do_step(cur, 20, 0, 0, 1'b0, 1'b0);
    chk("lit_int2", dut_v(3), 14);
    chk("lit_int2_spk", int'(spikes), 0);
    do_step(cur, 20, 0, 0, 1'b0, 1'b0);
    chk("lit_int3_spk", int'(spikes), 15);
    for (int n = 0; n < N; n++) chk("lit_int3_v", dut_v(n), 1);

    // Leak on both signs.
    do_reset();
    cur = {8'd0, 8'd0, 8'hF0, 8'd16};
    do_step(cur, 127, 1, 0, 1'b0, 1'b0);
    chk("lit_leak_p0", dut_v(0), 16);
    chk("lit_leak_n0", dut_v(1), -16);
    for (int s = 0; s < 5; s++) begin
      do_step('0, 127, 1, 0, 1'b0, 1'b0);
      chk("lit_leak_p", dut_v(0), leak_pos[s]);
      chk("lit_leak_n", dut_v(1), leak_neg[s]);
    end

    // Saturation at both rails.
    do_reset();
    cur = {8'd0, 8'd0, 8'h80, 8'd100};
    do_step(cur, 127, 0, 0, 1'b0, 1'b0);
    chk("lit_sat1_v0", dut_v(0), 100);
    do_step(cur, 127, 0, 0, 1'b0, 1'b0);
    chk("lit_sat2_v0", dut_v(0), 0);
    chk("lit_sat2_v1", dut_v(1), -128);
    chk("lit_sat2_spk", int'(spikes), 1);

    // Refractory period with a start poked while busy.
    do_reset();
    cur = {4{8'd10}};
    for (int s = 1; s <= 4; s++) begin
      do_step(cur, 10, 0, 2, 1'b0, s == 2);
      chk("lit_refr_spk", int'(spikes), (s == 1 || s == 4) ? 15 : 0);
      chk("lit_refr_v", dut_v(2), 0);
    end

`ifdef LIF_BANK_SPIKE_COUNT_EN
    do_reset();
    cur = {4{8'd1}};
    repeat (3) do_step(cur, 1, 0, 0, 1'b0, 1'b0);
    chk("lit_count3", dut_cnt(0), 3);
    do_step('0, 1, 0, 0, 1'b1, 1'b0);
    chk("lit_count_clr", dut_cnt(0), 0);
`endif

    // Reset mid-timestep aborts with no done.
    @(negedge clk);
    start          = 1'b1;
    input_currents = {4{8'd50}};
    threshold      = 8'sd1;
    decay          = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      chk("abort_done", int'(done), 0);
      chk("abort_busy", int'(busy), 0);
    end
    chk("abort_spikes", int'(spikes), 0);
    for (int n = 0; n < N; n++) chk("abort_v", dut_v(n), 0);

    // Randomized timesteps.
    for (int r = 0; r < 80; r++) begin
      int thr;
      thr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) - 128
                                         : int'($urandom_range(60, 0)) - 5;
      do_step($urandom, thr, int'($urandom_range(7, 0)),
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : int'($urandom_range(3, 0)),
              1'($urandom_range(7, 0) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
